// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the IF stage: RV32I opcodes, link-register test and
// immediate extraction used by the static predictor.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [31:0] NOP = 32'h0000_0033;

  // x1 (ra) and x5 (t0) are the RISC-V link registers for RAS hints.
  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  function automatic logic [31:0] imm_J(input logic [31:0] ir);
    return {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] imm_B(input logic [31:0] ir);
    return {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_unit_ras.sv
// Circular return-address stack; overflow silently overwrites the oldest entry
// and count saturates at DEPTH.
module ras_stack #(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [31:0]                  push_val,
  output logic [31:0]                  top,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      entry_q [DEPTH];
  logic [31:0]      entry_d [DEPTH];

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    entry_d = entry_q;
    if (push) begin
      ptr_d          = ptr_q + 1'b1;
      entry_d[ptr_d] = push_val;
      count_d        = (count_q == FULL) ? count_q : count_q + 1'b1;
    end else if (pop) begin
      ptr_d   = ptr_q - 1'b1;
      count_d = count_q - 1'b1;
    end
  end

  // NOTE: the entries are a handful of flops, not a RAM macro, so resetting
  // them is cheap and keeps the predicted target deterministic after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
      entry_q <= entry_d;
    end
  end

  assign top   = entry_q[ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// IF stage: PC register, static branch/jump predictor with RAS, and the
// redirect > stall > predict next-PC mux.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_IF,
  output logic [31:0] ir_IF,
  output logic [31:0] ra_IF
);

  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pc_plus4;
  logic [6:0]       opcode;
  logic [4:0]       rd, rs1;
  logic             push_pred, pop_pred;
  logic             commit;
  logic [31:0]      ras_top;
  logic [CNT_W-1:0] ras_count;

  assign opcode   = imem_rdata[6:0];
  assign rd       = imem_rdata[11:7];
  assign rs1      = imem_rdata[19:15];
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    ra_IF     = pc_plus4;
    push_pred = 1'b0;
    pop_pred  = 1'b0;
    if (opcode == OP_JAL) begin
      ra_IF     = pc_q + imm_J(imem_rdata);
      push_pred = is_link(rd);
    end else if (opcode == OP_JALR) begin
      if (is_link(rd)) begin
        push_pred = 1'b1;
      end else if (is_link(rs1) && (ras_count != '0)) begin
        ra_IF    = ras_top;
        pop_pred = 1'b1;
      end
    end else if (opcode == OP_BRANCH) begin
      // Backward-taken / forward-not-taken, decided by the immediate sign.
      if (imem_rdata[31]) ra_IF = pc_q + imm_B(imem_rdata);
    end
  end

  // A held or flushed instruction must not disturb the RAS.
  assign commit = !stall && !redirect;

  always_comb begin
    pc_d = ra_IF;
    if (redirect)   pc_d = redirect_pc;
    else if (stall) pc_d = pc_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge value regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  ras_stack #(
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .rst      (rst),
    .push     (push_pred && commit),
    .pop      (pop_pred && commit),
    .push_val (pc_plus4),
    .top      (ras_top),
    .count    (ras_count)
  );

  assign imem_addr = pc_q;
  assign pc_IF     = pc_q;
  assign ir_IF     = imem_rdata;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a small word-addressed instruction memory
// answers combinationally; each scenario task checks pc_IF / ra_IF inline.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] ADDI = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc_IF;
  logic [31:0] ir_IF;
  logic [31:0] ra_IF;

  logic [31:0] mem [1024];
  int checks   = 0;
  int failures = 0;

  fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .RAS_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .pc_IF       (pc_IF),
    .ir_IF       (ir_IF),
    .ra_IF       (ra_IF)
  );

  always #5 clk = ~clk;

  always_comb begin
    if (imem_addr[31:12] != 20'd0 || imem_addr[1:0] != 2'd0) imem_rdata = NOP;
    else imem_rdata = mem[imem_addr[11:2]];
  end

  function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [31:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
  endfunction

  function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd0, rs1, 3'b000, rd, OP_JALR};
  endfunction

  function automatic logic [31:0] enc_beq(input logic [31:0] imm);
    return {imm[12], imm[10:5], 5'd0, 5'd0, 3'b000, imm[4:1], imm[11], OP_BRANCH};
  endfunction

  task automatic put(input logic [31:0] addr, input logic [31:0] word);
    mem[addr[11:2]] = word;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = ADDI;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic jump_to(input logic [31:0] addr);
    redirect = 1'b1; redirect_pc = addr;
    step();
    redirect = 1'b0;
  endtask

  task automatic expect_pc_ra(input string name, input logic [31:0] pc_exp,
                              input logic [31:0] ra_exp);
    checks++;
    if (pc_IF !== pc_exp || ra_IF !== ra_exp) begin
      failures++;
      $display("FAIL %s: pc_IF=%h ra_IF=%h, required pc_IF=%h ra_IF=%h",
               name, pc_IF, ra_IF, pc_exp, ra_exp);
    end
  endtask

  task automatic test_reset();
    clear_mem();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    #1;
    checks++;
    if (imem_addr !== 32'h0 || ir_IF !== ADDI) begin
      failures++;
      $display("FAIL reset_addr_ir: imem_addr=%h ir_IF=%h, required 0 / %h",
               imem_addr, ir_IF, ADDI);
    end
    expect_pc_ra("reset_hold", 32'h0, 32'h4);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_pc_ra($sformatf("seq_%0d", i), 32'(4 * i), 32'(4 * i + 4));
      step();
    end
  endtask

  task automatic test_call_return();
    clear_mem();
    do_reset();
    put(32'h10, enc_jal(5'd1, 32'h40));
    put(32'h50, enc_jalr(5'd0, 5'd1));
    put(32'h14, enc_jalr(5'd0, 5'd1));
    jump_to(32'h10);
    expect_pc_ra("call_jal", 32'h10, 32'h50);
    step();
    expect_pc_ra("call_ret", 32'h50, 32'h14);
    step();
    expect_pc_ra("ret_empty", 32'h14, 32'h18);
  endtask

  task automatic test_branch();
    clear_mem();
    do_reset();
    put(32'h20, enc_beq(32'hFFFF_FFF8));
    put(32'h18, enc_beq(32'h8));
    jump_to(32'h20);
    expect_pc_ra("beq_back", 32'h20, 32'h18);
    step();
    expect_pc_ra("beq_fwd", 32'h18, 32'h1C);
    step();
    expect_pc_ra("beq_fwd_next", 32'h1C, 32'h20);
  endtask

  task automatic test_stall_redirect();
    clear_mem();
    do_reset();
    put(32'h40, enc_jal(5'd1, 32'h20));
    put(32'h100, enc_jalr(5'd0, 5'd1));
    jump_to(32'h40);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_pc_ra($sformatf("stall_%0d", i), 32'h40, 32'h60);
    end
    redirect = 1'b1; redirect_pc = 32'h100;
    step();
    stall = 1'b0; redirect = 1'b0;
    // RAS stayed empty: the return at 0x100 falls back to pc+4.
    expect_pc_ra("stall_redirect", 32'h100, 32'h104);
    jump_to(32'h102);
    expect_pc_ra("misaligned_redirect", 32'h102, 32'h106);
  endtask

  task automatic test_ras_overflow();
    logic [31:0] call_pc [5] = '{32'h0, 32'h100, 32'h200, 32'h300, 32'h400};
    logic [31:0] ret_pc  [5] = '{32'h500, 32'h404, 32'h304, 32'h204, 32'h104};
    logic [31:0] ret_ra  [5] = '{32'h404, 32'h304, 32'h204, 32'h104, 32'h108};
    clear_mem();
    for (int i = 0; i < 5; i++) put(call_pc[i], enc_jal(5'd1, 32'h100));
    for (int i = 0; i < 5; i++) put(ret_pc[i], enc_jalr(5'd0, 5'd1));
    do_reset();
    for (int i = 0; i < 5; i++) begin
      expect_pc_ra($sformatf("nest_call_%0d", i), call_pc[i], call_pc[i] + 32'h100);
      step();
    end
    for (int i = 0; i < 5; i++) begin
      expect_pc_ra($sformatf("nest_ret_%0d", i), ret_pc[i], ret_ra[i]);
      step();
    end
  endtask

  task automatic test_async_reset();
    clear_mem();
    do_reset();
    put(32'h7C, enc_jal(5'd1, 32'h4));
    put(32'h80, enc_jalr(5'd0, 5'd1));
    jump_to(32'h7C);
    step();
    expect_pc_ra("pre_reset_ret", 32'h80, 32'h80);
    #2 rst = 1'b1;
    #1;
    expect_pc_ra("async_reset", 32'h0, 32'h4);
    step();
    rst = 1'b0;
    jump_to(32'h80);
    expect_pc_ra("post_reset_ras_empty", 32'h80, 32'h84);
  endtask

  initial begin
    test_reset();
    test_call_return();
    test_branch();
    test_stall_redirect();
    test_ras_overflow();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- IF stage of the 5-stage RV32I pipeline. Directly upstream of the IF/ID pipeline register.
- Holds the PC and drives the combinational instruction-memory address.
- Predicts the next PC with a static branch predictor and a return-address stack (RAS).
- Produces pc_IF, ir_IF and ra_IF (predicted next PC) for IF/ID. EX compares ra against the resolved target and redirects on mismatch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- RAS_DEPTH, 4, number of RAS entries (power of two, >= 2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- stall  in  1  hazard-unit stall; hold PC and RAS.
- redirect  in  1  EX misprediction or jump correction; load redirect_pc.
- redirect_pc  in  32  corrected target from EX.
- imem_addr  out  32  instruction memory address; equals pc.
- imem_rdata  in  32  instruction word, combinational read of imem_addr.
- pc_IF  out  32  current PC.
- ir_IF  out  32  equals imem_rdata.
- ra_IF  out  32  predicted next PC for this instruction.

Behaviour:
- Reset (async, rst=1): pc=RESET_PC, RAS count=0, RAS pointer=0, RAS entries=0.
  - Outputs during reset: pc_IF=imem_addr=RESET_PC; ra_IF derived from imem_rdata as below.
- Prediction is combinational on ir=imem_rdata, evaluated in priority order:
  1. JAL (opcode 7'b1101111): ra_IF = pc + sext(imm_J). If rd is x1 or x5: push pc+4.
  2. JALR (7'b1100111), rd link (x1/x5): ra_IF = pc+4; push pc+4; no pop.
  3. JALR, rs1 link, rd not link, RAS count>0: ra_IF = top; pop.
  4. JALR otherwise, including pop on empty RAS: ra_IF = pc+4; RAS unchanged.
  5. Branch (7'b1100011): imm_B negative -> ra_IF = pc + sext(imm_B) (backward taken); else ra_IF = pc+4.
  6. Anything else: ra_IF = pc+4.
- Arithmetic: all adds are 32-bit modulo 2^32, no overflow flag. Immediates are sign-extended per the RV32I encoding.
- Next PC, with priority redirect > stall > predict:
  - redirect=1: pc <= redirect_pc.
  - stall=1 and redirect=0: pc holds.
  - else: pc <= ra_IF.
- Fetch latency: instruction at address A appears on ir_IF in the same cycle pc=A. Next instruction follows 1 cycle later.
- RAS commit: push/pop take effect at the clock edge only when stall=0 and redirect=0. Otherwise there is no RAS change; the instruction is being held or flushed.
- RAS organisation: circular buffer of RAS_DEPTH entries.
  - push: ptr <= ptr+1 (wraps); entry[ptr+1] <= value; count <= min(count+1, RAS_DEPTH). Overflow overwrites the oldest entry.
  - pop: ptr <= ptr-1 (wraps); count <= count-1. top = entry[ptr].
  - Pop with count=0 never occurs (rule 4).
- Redirect does not repair the RAS; wrong-path push/pop committed earlier remain. This accuracy loss is accepted.
- Simultaneous stall and redirect: redirect wins; PC loads redirect_pc; RAS unchanged.
- Reset mid-operation: immediate return to reset values regardless of stall or redirect.
- pc[1:0] is never checked. Misaligned redirect_pc is passed through unchanged.

Decomposition:
- Shared package:
  - opcode constants OP_JAL, OP_JALR, OP_BRANCH
  - NOP = 32'h0000_0033
  - is_link(reg) function (x1/x5)
  - immediate extraction functions imm_J and imm_B
  - RESET_PC default
- One sub-module, ras_stack: circular RAS with push, pop, push_val, top, count; parameterised by RAS_DEPTH.
- fetch_unit keeps the PC register, predictor decode and next-PC mux.

Test Plan:
- Reset then run: rst high 2 cycles, imem returns ADDI everywhere -> pc_IF sequence 0,4,8,12; ra_IF = pc+4 each cycle.
- Call/return: pc=0x10 JAL x1,+0x40 -> ra_IF=0x50, next pc=0x50. At 0x50 JALR x0,0(x1) -> ra_IF=0x14, next pc=0x14; RAS count back to 0.
- Backward branch: pc=0x20 BEQ imm=-8 -> ra_IF=0x18. Forward BEQ imm=+8 at 0x18 -> ra_IF=0x1C.
- Stall/redirect priority: stall=1 for 3 cycles -> pc holds, RAS count holds. stall=1 with redirect=1, redirect_pc=0x100 -> next pc=0x100. JAL x1 under stall -> no push.
- RAS overflow: RAS_DEPTH=4, 5 nested JAL x1 from pcs 0x0,0x100,0x200,0x300,0x400 -> 4 returns predict 0x404,0x304,0x204,0x104. 5th return (count=0) predicts pc+4.
- Async reset mid-run: assert rst between clock edges while pc=0x80 -> pc_IF=RESET_PC immediately; RAS count=0.
